// File: rtl/uart_regfile_bridge_pkg.sv
// uart_regfile_bridge_pkg: opcodes, response bytes and FSM states shared by the bridge.
package uart_regfile_bridge_pkg;
    localparam logic [2:0] OPC_READ  = 3'b101;
    localparam logic [2:0] OPC_WRITE = 3'b110;
    localparam logic [7:0] RESP_ACK  = 8'hA5;
    localparam logic [7:0] RESP_NAK  = 8'h5A;
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_TX    = 3'd1,
        WR_RX    = 3'd2,
        WR_DRAIN = 3'd3,
        COMMIT   = 3'd4,
        RESP     = 3'd5
    } state_t;
endpackage

// File: rtl/uart_regfile_bridge_rx_watchdog.sv
// uart_rx_watchdog: idle-cycle counter that pulses expire after LIMIT enabled cycles without a clear.
module uart_rx_watchdog #(
    parameter int LIMIT = 65535
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);
    localparam int CW = LIMIT > 1 ? $clog2(LIMIT) : 1;
    logic [CW-1:0] cnt;
    assign expire = (LIMIT != 0) && en && !clr && (cnt == CW'(LIMIT - 1));
    always_ff @(posedge clk) begin
        if (rst || clr || !en || expire) cnt <= '0;
        else cnt <= cnt + CW'(1);
    end
endmodule

// File: rtl/uart_regfile_bridge.sv
// uart_regfile_bridge: decodes UART read/write command bytes into a flat register file
// and answers with serialised register bytes or ACK/NAK.
module uart_regfile_bridge
    import uart_regfile_bridge_pkg::*;
#(
    parameter int                W_REG       = 32,
    parameter int                N_REGS      = 8,
    parameter logic [W_REG-1:0]  RESET_VAL   = '0,
    parameter int                TIMEOUT_CYC = 65535
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [7:0]                rx_data,
    input  logic                      rx_valid,
    output logic                      rx_ready,
    output logic [7:0]                tx_data,
    output logic                      tx_valid,
    input  logic                      tx_ready,
    output logic [N_REGS*W_REG-1:0]   regs_o,
    output logic [N_REGS-1:0]         wr_stb,
    output logic                      err_timeout
);
    localparam int NB = W_REG / 8;
    localparam int BW = NB > 1 ? $clog2(NB) : 1;
    state_t state, state_nx;
    logic [N_REGS*W_REG-1:0] regs_q;
    logic [W_REG-1:0] shreg, asm_val;
    logic [BW-1:0] cnt;
    logic [4:0] addr;
    logic [7:0] resp;
    logic acc, txh, last, expire, addr_ok;
    assign acc = rx_valid && rx_ready;
    assign txh = tx_valid && tx_ready;
    assign last = cnt == BW'(NB - 1);
    assign addr_ok = int'(rx_data[4:0]) < N_REGS;
    // Bytes land in order into a cleared register, so OR-ing in the current byte yields the full word.
    assign asm_val = shreg | (W_REG'(rx_data) << (8 * int'(cnt)));
    assign regs_o = regs_q;
    uart_rx_watchdog #(.LIMIT(TIMEOUT_CYC)) u_wdog (
        .clk(clk),
        .rst(rst),
        .clr(acc),
        .en(state == WR_RX || state == WR_DRAIN),
        .expire(expire)
    );
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= state_nx;
    end
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     if (acc) state_nx = (rx_data[7:5] == OPC_READ && addr_ok) ? RD_TX :
                                          (rx_data[7:5] == OPC_WRITE) ? (addr_ok ? WR_RX : WR_DRAIN) : RESP;
            RD_TX:    if (txh && last) state_nx = IDLE;
            WR_RX:    state_nx = expire ? IDLE : (acc && last) ? COMMIT : WR_RX;
            WR_DRAIN: state_nx = expire ? IDLE : (acc && last) ? RESP : WR_DRAIN;
            COMMIT:   state_nx = RESP;
            RESP:     if (txh) state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end
    always_comb begin
        rx_ready = !rst && (state == IDLE || state == WR_RX || state == WR_DRAIN);
        tx_valid = state == RD_TX || state == RESP;
        tx_data  = state == RD_TX ? shreg[7:0] : state == RESP ? resp : 8'h00;
        wr_stb   = state == COMMIT ? N_REGS'(1) << addr : '0;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            regs_q      <= {N_REGS{RESET_VAL}};
            shreg       <= '0;
            cnt         <= '0;
            addr        <= '0;
            resp        <= '0;
            err_timeout <= 1'b0;
        end else begin
            err_timeout <= expire;
            case (state)
                IDLE: if (acc) begin
                    addr  <= rx_data[4:0];
                    cnt   <= '0;
                    resp  <= RESP_NAK;
                    shreg <= (rx_data[7:5] == OPC_READ && addr_ok) ?
                             regs_q[int'(rx_data[4:0]) * W_REG +: W_REG] : '0;
                end
                RD_TX: if (txh) begin
                    shreg <= shreg >> 8;
                    cnt   <= cnt + BW'(1);
                end
                WR_RX, WR_DRAIN: if (acc) begin
                    shreg <= asm_val;
                    cnt   <= cnt + BW'(1);
                    if (state == WR_RX && last) regs_q[int'(addr) * W_REG +: W_REG] <= asm_val;
                end
                COMMIT: resp <= RESP_ACK;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_regfile_bridge.sv
// tb_uart_regfile_bridge: directed vectors against a 32x8 bridge (timeout 16) and a 16x32 bridge.
module tb_uart_regfile_bridge;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sel = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic rx_valid = 1'b0;
    logic tx_ready = 1'b0;
    logic rx_ready_a, tx_valid_a, err_a, rx_ready_b, tx_valid_b, err_b;
    logic [7:0] tx_data_a, tx_data_b;
    logic [255:0] regs_a;
    logic [511:0] regs_b;
    logic [7:0] stb_a;
    logic [31:0] stb_b;
    logic rdy, tv;
    logic [7:0] td;
    int checks = 0;
    int failures = 0;
    always #5 clk = ~clk;
    assign rdy = sel ? rx_ready_b : rx_ready_a;
    assign tv  = sel ? tx_valid_b : tx_valid_a;
    assign td  = sel ? tx_data_b : tx_data_a;
    uart_regfile_bridge #(.W_REG(32), .N_REGS(8), .RESET_VAL(32'h0), .TIMEOUT_CYC(16)) dut_a (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid && !sel), .rx_ready(rx_ready_a),
        .tx_data(tx_data_a), .tx_valid(tx_valid_a), .tx_ready(tx_ready && !sel),
        .regs_o(regs_a), .wr_stb(stb_a), .err_timeout(err_a)
    );
    uart_regfile_bridge #(.W_REG(16), .N_REGS(32), .RESET_VAL(16'h0), .TIMEOUT_CYC(65535)) dut_b (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid && sel), .rx_ready(rx_ready_b),
        .tx_data(tx_data_b), .tx_valid(tx_valid_b), .tx_ready(tx_ready && sel),
        .regs_o(regs_b), .wr_stb(stb_b), .err_timeout(err_b)
    );
    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        rx_data = b;
        rx_valid = 1'b1;
        while (!rdy && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("rx_ready_timeout", 64'(n), 64'(0));
        @(posedge clk);
        @(negedge clk);
        rx_valid = 1'b0;
    endtask
    task automatic recv_byte(input string tag, input logic [7:0] exp, input int stall);
        int n = 0;
        while (!tv && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk({tag, "_tx_valid_timeout"}, 64'(n), 64'(0));
        for (int s = 0; s < stall; s++) begin
            chk({tag, "_stalled"}, {56'h0, td}, {56'h0, exp});
            @(negedge clk);
        end
        tx_ready = 1'b1;
        chk(tag, {56'h0, td}, {56'h0, exp});
        @(posedge clk);
        @(negedge clk);
        tx_ready = 1'b0;
    endtask
    initial begin
        int n;
        repeat (2) @(negedge clk);
        chk("rst_rx_ready", {63'h0, rx_ready_a}, 64'h0);
        chk("rst_tx_valid", {63'h0, tx_valid_a}, 64'h0);
        chk("rst_tx_data", {56'h0, tx_data_a}, 64'h0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_regs", 64'(regs_a != 256'h0), 64'h0);
        chk("idle_rx_ready", {63'h0, rx_ready_a}, 64'h1);
        // write 0x12345678 into reg 3
        send_byte(8'hC3);
        send_byte(8'h78);
        send_byte(8'h56);
        send_byte(8'h34);
        send_byte(8'h12);
        chk("wr_stb", {56'h0, stb_a}, 64'h08);
        chk("reg3", {32'h0, regs_a[127:96]}, 64'h12345678);
        chk("commit_rx_ready", {63'h0, rx_ready_a}, 64'h0);
        @(negedge clk);
        chk("wr_stb_one_cycle", {56'h0, stb_a}, 64'h0);
        chk("ack_valid", {63'h0, tx_valid_a}, 64'h1);
        recv_byte("ack", 8'hA5, 2);
        chk("ack_done", {63'h0, tx_valid_a}, 64'h0);
        // read reg 3 with stalls
        send_byte(8'hA3);
        chk("rd_turnaround", {63'h0, tx_valid_a}, 64'h1);
        recv_byte("rd_b0", 8'h78, 2);
        recv_byte("rd_b1", 8'h56, 0);
        recv_byte("rd_b2", 8'h34, 3);
        recv_byte("rd_b3", 8'h12, 1);
        chk("rd_done", {63'h0, tx_valid_a}, 64'h0);
        // write to out-of-range address 9 is drained and NAKed
        send_byte(8'hC9);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h44);
        chk("drain_no_stb", {56'h0, stb_a}, 64'h0);
        recv_byte("drain_nak", 8'h5A, 0);
        chk("drain_regs3", {32'h0, regs_a[127:96]}, 64'h12345678);
        chk("drain_others", 64'(regs_a[255:128] != 128'h0 || regs_a[95:0] != 96'h0), 64'h0);
        send_byte(8'h03);
        recv_byte("bad_opc_nak", 8'h5A, 0);
        send_byte(8'hA9);
        recv_byte("rd_oob_nak", 8'h5A, 0);
        // timeout after two data bytes
        send_byte(8'hC1);
        send_byte(8'h11);
        send_byte(8'h22);
        n = 0;
        while (!err_a && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("timeout_delay", 64'(n), 64'd16);
        chk("timeout_no_tx", {63'h0, tx_valid_a}, 64'h0);
        @(negedge clk);
        chk("timeout_pulse", {63'h0, err_a}, 64'h0);
        chk("timeout_no_write", {32'h0, regs_a[63:32]}, 64'h0);
        send_byte(8'hA1);
        recv_byte("to_rd_b0", 8'h00, 0);
        recv_byte("to_rd_b1", 8'h00, 0);
        recv_byte("to_rd_b2", 8'h00, 0);
        recv_byte("to_rd_b3", 8'h00, 0);
        // reset in the middle of a read
        send_byte(8'hA3);
        recv_byte("rst_rd_b0", 8'h78, 0);
        chk("pre_rst_valid", {63'h0, tx_valid_a}, 64'h1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_tx_valid", {63'h0, tx_valid_a}, 64'h0);
        chk("mid_rst_regs", 64'(regs_a != 256'h0), 64'h0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_idle", {63'h0, rx_ready_a}, 64'h1);
        // 16-bit registers, address 31
        sel = 1'b1;
        send_byte(8'hDF);
        send_byte(8'hEF);
        send_byte(8'hBE);
        chk("b_wr_stb", {32'h0, stb_b}, 64'h80000000);
        chk("b_reg31", {48'h0, regs_b[511:496]}, 64'hBEEF);
        recv_byte("b_ack", 8'hA5, 0);
        send_byte(8'hBF);
        recv_byte("b_rd_b0", 8'hEF, 1);
        recv_byte("b_rd_b1", 8'hBE, 0);
        chk("b_rd_done", {63'h0, tx_valid_b}, 64'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
